// File: rtl/midi_note_decoder.sv
// midi_note_decoder: monophonic last-note-priority MIDI channel-voice decoder with running status.
module midi_note_decoder #(
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       new_note_pulse,
    output logic       release_note_pulse,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       note_active
);
    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    state_t     r_state;
    logic       r_rs_valid;
    logic [3:0] r_type;
    logic [3:0] r_chan;
    logic [6:0] r_d1;

    logic w_status, w_syscom, w_take_d1, w_take_d2, w_one_byte, w_ch_ok, w_on, w_off, w_ano;

    always_comb begin
        w_status   = rx_data[7] && (rx_data[7:4] != 4'hF);
        w_syscom   = rx_data[7:3] == 5'b11110;
        w_take_d1  = !rx_data[7] && (r_state == WAIT_D1 || (r_state == IDLE && r_rs_valid));
        w_take_d2  = !rx_data[7] && (r_state == WAIT_D2);
        w_one_byte = (r_type == 4'hC) || (r_type == 4'hD);
        w_ch_ok    = (OMNI != 0) || (r_chan == MIDI_CHANNEL[3:0]);
        w_on       = (r_type == 4'h9) && (rx_data[6:0] != 7'd0);
        // Velocity-0 note-on lands here only because w_on is checked first.
        w_off      = ((r_type == 4'h8) || (r_type == 4'h9)) && note_active && (r_d1 == note);
        w_ano      = (r_type == 4'hB) && (r_d1 == 7'd123) && note_active;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state            <= IDLE;
            r_rs_valid         <= 1'b0;
            r_type             <= 4'h0;
            r_chan             <= 4'h0;
            r_d1               <= 7'd0;
            new_note_pulse     <= 1'b0;
            release_note_pulse <= 1'b0;
            note               <= 7'd0;
            velocity           <= 7'd0;
            note_active        <= 1'b0;
        end else begin
            new_note_pulse     <= 1'b0;
            release_note_pulse <= 1'b0;
            if (rx_valid) begin
                if (w_status) begin
                    r_type     <= rx_data[7:4];
                    r_chan     <= rx_data[3:0];
                    r_rs_valid <= 1'b1;
                    r_state    <= WAIT_D1;
                end else if (w_syscom) begin
                    r_rs_valid <= 1'b0;
                    r_state    <= IDLE;
                end else if (w_take_d1) begin
                    r_d1    <= rx_data[6:0];
                    r_state <= w_one_byte ? WAIT_D1 : WAIT_D2;
                end else if (w_take_d2) begin
                    r_state <= WAIT_D1;
                    if (w_ch_ok) begin
                        if (w_on) begin
                            note           <= r_d1;
                            velocity       <= rx_data[6:0];
                            note_active    <= 1'b1;
                            new_note_pulse <= 1'b1;
                        end else if (w_off || w_ano) begin
                            note_active        <= 1'b0;
                            release_note_pulse <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/midi_note_decoder.md
# midi_note_decoder

Parses the byte stream from the MIDI UART receiver and turns channel-voice messages into the note-event controls consumed by the ADSR envelope stage (`new_note_pulse`, `release_note_pulse`) plus the note number and velocity used by the oscillator and level stages. It is a monophonic, last-note-priority decoder that supports running status, velocity-0 note-off, and All-Notes-Off. Realtime bytes pass through it without disturbing an in-progress message.

## Interface
Parameters:
- `MIDI_CHANNEL`, default 0: channel number (0-15) this decoder responds to.
- `OMNI`, default 0: when 1, messages on every channel are accepted and `MIDI_CHANNEL` is ignored.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received MIDI byte; valid only when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe, one per received byte. There is no back-pressure, and every strobe is consumed.
- `new_note_pulse`  out  1  one-cycle pulse on an accepted note-on.
- `release_note_pulse`  out  1  one-cycle pulse when the sounding note is released.
- `note`  out  7  note number of the last accepted note-on; held after release.
- `velocity`  out  7  velocity of the last accepted note-on; held after release.
- `note_active`  out  1  high from note-on until its matching release.

## Operation
- **Byte classes**
  - Status byte: bit7 = 1 and value in 0x80-0xEF.
  - System common: 0xF0-0xF7.
  - Realtime: 0xF8-0xFF.
  - Data byte: bit7 = 0.
- **Realtime bytes** are ignored entirely. State, running status and partially received data are untouched, so a realtime byte may appear between any two bytes.
- **System common bytes** clear running status. The FSM goes to IDLE. Subsequent data bytes are discarded until a new status byte arrives; this covers SysEx payloads.
- **Status byte** (0x80-0xEF) latches the running status (type = bits 7:4, channel = bits 3:0) and moves the FSM to WAIT_D1.
- **FSM states:** IDLE, WAIT_D1, WAIT_D2.
  - IDLE: a data byte is discarded unless running status is valid, in which case it is treated as D1 (running status).
  - WAIT_D1: a data byte is latched as D1.
    - Types 0xC and 0xD: the message is complete; it is discarded and the FSM returns to WAIT_D1.
    - All other types: go to WAIT_D2.
  - WAIT_D2: a data byte completes the message, which is executed, and the FSM returns to WAIT_D1 (running status remains valid).
  - A status byte received in any state restarts at WAIT_D1, and any partial message is dropped.
- **Channel filter:** a completed message executes only if `OMNI` = 1 or the latched channel equals `MIDI_CHANNEL`. Otherwise it is parsed and dropped.
- **Execution**
  - Note-on (0x9) with velocity > 0:
    - Load `note` = D1 and `velocity` = D2.
    - Set `note_active`.
    - Pulse `new_note_pulse`.
    - This applies even if a note is already active (retrigger or legato steal); no release pulse is generated in that case.
  - Note-off (0x8), or 0x9 with velocity 0:
    - If `note_active` is set and D1 equals `note`: clear `note_active` and pulse `release_note_pulse`.
    - Otherwise there is no effect. A stale note-off for a stolen note must not release the current note.
  - Control change (0xB) with D1 = 123 (All Notes Off), any D2: if `note_active` is set, clear it and pulse `release_note_pulse`.
  - All other messages are dropped.
- **Pulses:** `new_note_pulse` and `release_note_pulse` are never high in the same cycle.

## Timing
- All outputs are registered.
- **Reset values:**
  - `new_note_pulse` = 0
  - `release_note_pulse` = 0
  - `note` = 0
  - `velocity` = 0
  - `note_active` = 0
  - Running status invalid; FSM in IDLE.
- **Reset mid-message:** any partial message is lost. Pulses deassert immediately, since the reset is asynchronous.
- **Latency:** if the final data byte is sampled with `rx_valid` at clock edge N, then the pulse, `note`, `velocity` and `note_active` update on edge N+1 as registered values. The pulse is high for exactly one cycle.
- **Strobe spacing:** back-to-back `rx_valid` on consecutive cycles must be handled; each byte is processed in its own cycle. No minimum spacing is required.
- **Data width:** D1 and D2 are stored as 7 bits; bit7 is not stored.

## Test plan
- **Basic note on/off:** after reset, send 0x90,0x3C,0x64 → one `new_note_pulse`, `note` = 0x3C, `velocity` = 0x64, `note_active` = 1. Then send 0x80,0x3C,0x40 → one `release_note_pulse`, `note_active` = 0, `note` still 0x3C.
- **Running status and velocity-0 release:** send 0x90,0x40,0x50,0x40,0x00 → one new pulse followed by one release pulse. Then send 0x45,0x7F → new pulse with `note` = 0x45.
- **Note stealing:** send 0x90,0x3C,0x64 then 0x90,0x43,0x20 → two new pulses, `note` = 0x43. Then 0x80,0x3C,0x00 → no release. Then 0x80,0x43,0x00 → release.
- **Interleaved realtime and filtered channels:** send 0x90,0xF8,0x3C,0xFE,0x64 → note-on for 0x3C. With `MIDI_CHANNEL` = 0, send 0x91,0x30,0x40 → no pulse; repeat with `OMNI` = 1 → pulse.
- **System common and All Notes Off:** with a note active, send 0xF0,0x01,0x02,0xF7 and then data bytes 0x3C,0x00 → no effect. Then send 0xB0,0x7B,0x00 → `release_note_pulse`. Send 0xC0,0x05 → no effect.
- **Asynchronous reset mid-message:** assert `rst` = 0 asynchronously while in WAIT_D2 → all outputs read 0 immediately. After release, send data byte 0x64 → ignored, because running status was cleared by reset.
